banked_ram: RTL

Parametrised, chip-select-banked synchronous RAM for the lab memory subsystem. It is the generalised successor to the fixed 4-bank, 256-word by 32-bit memory: data width, address width and bank count are parameters. It adds byte-enabled writes, an explicit read strobe with a registered, valid-flagged read port, and a post-reset clear sequencer that zeroes every bank before accepting traffic. It sits behind the CPU/testbench address bus, with the top address bits decoded as chip select.

---
 rtl/banked_ram_pkg.sv | 27 ++
 rtl/banked_ram_bank.sv | 39 +++
 rtl/banked_ram.sv | 110 +++++++++++
 3 files changed

// File: rtl/banked_ram_pkg.sv
// banked_ram_pkg: shared types and helpers for the banked RAM.
//   state_t      - sequencer states (CLEAR zeroes the banks, RUN serves traffic)
//   DEF_*        - default parameter values for banked_ram
//   bank_decode  - bank index to one-hot chip select (up to MAX_NBANK banks)
package banked_ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_BANK_W = 2;

   // Widest bank select the decode helper supports; callers cast the result
   // down to their own bank count.
   localparam int MAX_BANK_W = 6;
   localparam int MAX_NBANK  = 1 << MAX_BANK_W;

   function automatic logic [MAX_NBANK-1:0] bank_decode(input logic [MAX_BANK_W-1:0] bank);
      logic [MAX_NBANK-1:0] one;
      one = {{(MAX_NBANK-1){1'b0}}, 1'b1};
      return one << bank;
   endfunction

endpackage

// File: rtl/banked_ram_bank.sv
// ram_bank: one DEPTH x DATA_W storage bank.
//   clk, reset - clock and synchronous active-high reset (clears only rdata)
//   we, byte_en, addr, wdata - byte-enabled write port
//   rd         - read strobe; rdata is loaded from mem[addr] on the edge
//   rdata      - registered read data, holds between reads
module ram_bank #(
   parameter int DATA_W = 32,
   parameter int WORD_W = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   byte_en,
   input  logic [WORD_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  rd,
   output logic [DATA_W-1:0]     rdata
);

   localparam int DEPTH = 1 << WORD_W;
   localparam int NBYTE = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage has no reset; contents are zeroed by the top-level clear sequencer.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NBYTE; i++) begin
            if (byte_en[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)   rdata <= '0;
      else if (rd) rdata <= mem[addr];
   end

endmodule

// File: rtl/banked_ram.sv
// banked_ram: chip-select-banked synchronous RAM with post-reset clear.
//   clk, reset         - clock, synchronous active-high reset
//   Address            - word address; top BANK_W bits select the bank
//   Write, Read        - access strobes (write wins when both are set)
//   In, ByteEn         - write data and per-byte write enable
//   Dout, DoutValid    - registered read data and one-cycle read pulse
//   CS                 - one-hot bank of the last accepted access
//   Ready              - high once the clear sequence has finished
import banked_ram_pkg::*;

module banked_ram #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int BANK_W = DEF_BANK_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_W-1:0]         Address,
   input  logic                      Write,
   input  logic                      Read,
   input  logic [DATA_W-1:0]         In,
   input  logic [DATA_W/8-1:0]       ByteEn,
   output logic [DATA_W-1:0]         Dout,
   output logic                      DoutValid,
   output logic [(1<<BANK_W)-1:0]    CS,
   output logic                      Ready
);

   localparam int NBANK  = 1 << BANK_W;
   localparam int WORD_W = ADDR_W - BANK_W;
   localparam int NBYTE  = DATA_W / 8;

   state_t            state;
   logic [WORD_W-1:0] cnt;
   logic [BANK_W-1:0] rd_sel;

   logic [BANK_W-1:0] bank;
   logic [WORD_W-1:0] word;
   logic [NBANK-1:0]  dec;

   logic clearing, run_ok, wr_acc, rd_acc;

   logic [WORD_W-1:0] bank_addr;
   logic [NBYTE-1:0]  bank_be;
   logic [DATA_W-1:0] bank_wdata;
   logic [DATA_W-1:0] bank_rdata [NBANK];

   assign bank = Address[ADDR_W-1 -: BANK_W];
   assign word = Address[WORD_W-1:0];
   assign dec  = NBANK'(bank_decode(MAX_BANK_W'(bank)));

   // Reset gates everything so no bank is touched on a reset edge.
   assign clearing = (state == CLEAR) && !reset;
   assign run_ok   = (state == RUN)   && !reset;
   assign wr_acc   = run_ok && Write;
   assign rd_acc   = run_ok && Read && !Write;

   // During clear all banks share the counter address and write zero.
   assign bank_addr  = clearing ? cnt : word;
   assign bank_be    = clearing ? '1  : ByteEn;
   assign bank_wdata = clearing ? '0  : In;

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      ram_bank #(
         .DATA_W (DATA_W),
         .WORD_W (WORD_W)
      ) u_bank (
         .clk     (clk),
         .reset   (reset),
         .we      (clearing || (wr_acc && dec[b])),
         .byte_en (bank_be),
         .addr    (bank_addr),
         .wdata   (bank_wdata),
         .rd      (rd_acc && dec[b]),
         .rdata   (bank_rdata[b])
      );
   end

   // Each bank holds its own last read word, so selecting the bank of the
   // last accepted read keeps Dout stable until the next read.
   assign Dout = bank_rdata[rd_sel];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= CLEAR;
         cnt       <= '0;
         Ready     <= 1'b0;
         DoutValid <= 1'b0;
         CS        <= '0;
         rd_sel    <= '0;
      end else begin
         case (state)
            CLEAR: begin
               Ready     <= 1'b0;
               DoutValid <= 1'b0;
               cnt       <= cnt + 1'b1;
               if (&cnt) state <= RUN;
            end
            RUN: begin
               Ready     <= 1'b1;
               DoutValid <= rd_acc;
               if (wr_acc || rd_acc) CS <= dec;
               if (rd_acc) rd_sel <= bank;
            end
            default: state <= CLEAR;
         endcase
      end
   end

endmodule
